// File: rtl/param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : param_datapath
// Purpose  : Parameterised bus datapath (GPRs, PC/IR/Y/MAR/MDR/HI/LO, 2W-bit Z)
//            with ALU and a multicycle shift-add multiply / restoring divide.
//            Optional bus-conflict checker: PARAM_DATAPATH_BUS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module param_datapath #(
  parameter int REG_SIZE = 32,
  parameter int NUM_GPR  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_GPR-1:0]  gpr_in,
  input  logic [NUM_GPR-1:0]  gpr_out,
  input  logic [7:0]          reg_in,
  input  logic [7:0]          src_out,
  input  logic                read,
  input  logic [REG_SIZE-1:0] m_data_in,
  input  logic [REG_SIZE-1:0] inport_data,
  input  logic [REG_SIZE-1:0] c_data,
  input  logic [3:0]          alu_op,
  input  logic                inc_pc,
  input  logic                md_start,
  input  logic                md_op,
  output logic                md_busy,
  output logic                md_done,
  output logic [REG_SIZE-1:0] bus_data,
  output logic [REG_SIZE-1:0] ir_data,
  output logic [REG_SIZE-1:0] mar_data,
  output logic [REG_SIZE-1:0] mdr_data,
  output logic                bus_error
);

  localparam int                c_sh_w  = $clog2(REG_SIZE);
  localparam logic [c_sh_w:0]   c_width = (c_sh_w + 1)'(REG_SIZE);
  localparam logic [c_sh_w-1:0] c_last  = c_sh_w'(REG_SIZE - 1);

  // reg_in bit positions
  localparam int c_r_hi  = 0;
  localparam int c_r_lo  = 1;
  localparam int c_r_pc  = 2;
  localparam int c_r_ir  = 3;
  localparam int c_r_z   = 4;
  localparam int c_r_y   = 5;
  localparam int c_r_mar = 6;
  localparam int c_r_mdr = 7;

  // src_out bit positions
  localparam int c_s_hi  = 0;
  localparam int c_s_lo  = 1;
  localparam int c_s_zh  = 2;
  localparam int c_s_zl  = 3;
  localparam int c_s_pc  = 4;
  localparam int c_s_mdr = 5;
  localparam int c_s_in  = 6;
  localparam int c_s_c   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  logic [REG_SIZE-1:0]   r_gpr [NUM_GPR];
  logic [REG_SIZE-1:0]   r_pc, r_ir, r_y, r_mar, r_mdr, r_hi, r_lo;
  logic [2*REG_SIZE-1:0] r_z;

  logic [REG_SIZE-1:0]   w_src [8];
  logic [REG_SIZE-1:0]   w_bus;

  md_state_t             r_state, w_next;
  logic [c_sh_w-1:0]     r_cnt;
  logic [REG_SIZE-1:0]   r_acc, r_q, r_m;
  logic                  r_op;
  logic                  w_start, w_last, w_busy, w_done;

  logic [REG_SIZE-1:0]   w_alu_a, w_alu_res;
  logic [c_sh_w-1:0]     w_sh;

  logic [REG_SIZE:0]     w_mul_sum, w_div_rem, w_div_diff;
  logic                  w_div_ok;
  logic [REG_SIZE-1:0]   w_step_acc, w_step_q;

  // --------------------------------------------------------------------------
  // Bus: lowest select index wins, GPRs ahead of the special sources
  // --------------------------------------------------------------------------
  always_comb begin
    w_src[c_s_hi]  = r_hi;
    w_src[c_s_lo]  = r_lo;
    w_src[c_s_zh]  = r_z[2*REG_SIZE-1:REG_SIZE];
    w_src[c_s_zl]  = r_z[REG_SIZE-1:0];
    w_src[c_s_pc]  = r_pc;
    w_src[c_s_mdr] = r_mdr;
    w_src[c_s_in]  = inport_data;
    w_src[c_s_c]   = c_data;
  end

  always_comb begin
    w_bus = '0;
    for (int i = 7; i >= 0; i--) begin
      if (src_out[i]) w_bus = w_src[i];
    end
    for (int i = NUM_GPR - 1; i >= 0; i--) begin
      if (gpr_out[i]) w_bus = r_gpr[i];
    end
  end

  assign bus_data = w_bus;
  assign ir_data  = r_ir;
  assign mar_data = r_mar;
  assign mdr_data = r_mdr;

  // --------------------------------------------------------------------------
  // ALU: A = 4 or Y, B = bus; shift/rotate amount from the low bits of B
  // --------------------------------------------------------------------------
  always_comb begin
    w_alu_a = inc_pc ? REG_SIZE'(4) : r_y;
    w_sh    = w_bus[c_sh_w-1:0];
    case (alu_op)
      4'd0:    w_alu_res = w_alu_a + w_bus;
      4'd1:    w_alu_res = w_alu_a - w_bus;
      4'd2:    w_alu_res = w_alu_a & w_bus;
      4'd3:    w_alu_res = w_alu_a | w_bus;
      4'd4:    w_alu_res = w_alu_a ^ w_bus;
      4'd5:    w_alu_res = w_alu_a << w_sh;
      4'd6:    w_alu_res = w_alu_a >> w_sh;
      4'd7:    w_alu_res = $unsigned($signed(w_alu_a) >>> w_sh);
      4'd8:    w_alu_res = (w_alu_a << w_sh) | (w_alu_a >> (c_width - {1'b0, w_sh}));
      4'd9:    w_alu_res = (w_alu_a >> w_sh) | (w_alu_a << (c_width - {1'b0, w_sh}));
      4'd10:   w_alu_res = REG_SIZE'(0) - w_bus;
      4'd11:   w_alu_res = ~w_bus;
      4'd12:   w_alu_res = w_bus;
      default: w_alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // One multiply/divide iteration. Multiply keeps {acc,q} as the shifting
  // product; divide keeps acc = partial remainder, q = dividend/quotient.
  // --------------------------------------------------------------------------
  always_comb begin
    w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
    w_div_rem  = {r_acc, r_q[REG_SIZE-1]};
    w_div_diff = w_div_rem - {1'b0, r_m};
    w_div_ok   = ~w_div_diff[REG_SIZE];
    if (r_op) begin
      w_step_acc = w_div_ok ? w_div_diff[REG_SIZE-1:0] : w_div_rem[REG_SIZE-1:0];
      w_step_q   = {r_q[REG_SIZE-2:0], w_div_ok};
    end else begin
      w_step_acc = w_mul_sum[REG_SIZE:1];
      w_step_q   = {w_mul_sum[0], r_q[REG_SIZE-1:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Multicycle unit FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_last  = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (md_start) begin
          w_next  = ST_RUN;
          w_start = 1'b1;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == c_last) begin
          w_next = ST_DONE;
          w_last = 1'b1;
        end
      end
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign md_busy = w_busy;
  assign md_done = w_done;

  // Operands are captured at start so later Y/bus activity cannot disturb them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_op  <= 1'b0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_q   <= md_op ? r_y : w_bus;
      r_m   <= md_op ? w_bus : r_y;
      r_op  <= md_op;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + c_sh_w'(1);
      r_acc <= w_step_acc;
      r_q   <= w_step_q;
    end
  end

  // --------------------------------------------------------------------------
  // Register file and special registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (gpr_in[i]) r_gpr[i] <= w_bus;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_pc  <= '0;
      r_ir  <= '0;
      r_y   <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_z   <= '0;
    end else begin
      if (reg_in[c_r_hi])  r_hi  <= w_bus;
      if (reg_in[c_r_lo])  r_lo  <= w_bus;
      if (reg_in[c_r_pc])  r_pc  <= w_bus;
      if (reg_in[c_r_ir])  r_ir  <= w_bus;
      if (reg_in[c_r_y])   r_y   <= w_bus;
      if (reg_in[c_r_mar]) r_mar <= w_bus;
      if (reg_in[c_r_mdr]) r_mdr <= read ? m_data_in : w_bus;
      // The multicycle unit owns Z from start until it returns to IDLE
      if (w_last)
        r_z <= {w_step_acc, w_step_q};
      else if (reg_in[c_r_z] && !w_busy && !w_start)
        r_z <= {REG_SIZE'(0), w_alu_res};
    end
  end

  // --------------------------------------------------------------------------
  // Optional multiple-driver detector
  // --------------------------------------------------------------------------
`ifdef PARAM_DATAPATH_BUS_CHECK_EN
  localparam int c_sel_w = NUM_GPR + 8;
  logic [c_sel_w-1:0] w_sel;
  logic               w_multi;
  logic               r_bus_error;

  assign w_sel   = {src_out, gpr_out};
  assign w_multi = |(w_sel & (w_sel - c_sel_w'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_bus_error <= 1'b0;
    else          r_bus_error <= w_multi;
  end

  assign bus_error = r_bus_error;
`else
  assign bus_error = 1'b0;
`endif

endmodule
`default_nettype wire
